// File: rtl/exc_commit_if.sv
// MEM->WB instruction handoff plus the CP0 exception/ERET/MTC0 commit signals.
// The slave modport belongs to the commit stage; the master modport belongs to its environment.
interface exc_commit_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_bd;
  logic [6:0]  ms_exc;
  logic [31:0] ms_data_addr;
  logic        ms_eret;
  logic        ms_mtc0;
  logic [7:0]  ms_cp0_addr;
  logic [31:0] ms_cp0_wdata;
  logic        has_int;
  logic [31:0] epc;
  logic        ex;
  logic [4:0]  excode;
  logic        bd;
  logic [31:0] m2s_pc;
  logic [31:0] badvaddr;
  logic        eret_flush;
  logic        mtc0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic [31:0] flush_pc;

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_bd, ms_exc, ms_data_addr, ms_eret, ms_mtc0,
           ms_cp0_addr, ms_cp0_wdata, has_int, epc,
    output ws_allowin, ex, excode, bd, m2s_pc, badvaddr, eret_flush, mtc0_we,
           cp0_addr, cp0_wdata, flush, flush_pc
  );

  modport master (
    output ms_to_ws_valid, ms_pc, ms_bd, ms_exc, ms_data_addr, ms_eret, ms_mtc0,
           ms_cp0_addr, ms_cp0_wdata, has_int, epc,
    input  ws_allowin, ex, excode, bd, m2s_pc, badvaddr, eret_flush, mtc0_we,
           cp0_addr, cp0_wdata, flush, flush_pc
  );
endinterface

// File: rtl/exc_commit.sv
// Writeback-stage exception commit: latches one instruction, resolves its highest-priority
// exception, and raises the CP0 strobes and a one-cycle pipeline flush.
module exc_commit (
  input  logic          clk,
  input  logic          reset,
  exc_commit_if.slave   bus
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e      state_q, state_d;
  logic        wsValid_q, wsValid_d;
  logic [31:0] pc_q;
  logic        bd_q;
  logic [6:0]  exc_q;
  logic        intTag_q;
  logic [31:0] dataAddr_q;
  logic        eret_q;
  logic        mtc0_q;
  logic [7:0]  cp0Addr_q;
  logic [31:0] cp0Wdata_q;

  logic        inRun;
  logic        exStrobe;
  logic        eretStrobe;
  logic        flushNow;
  logic        load;
  logic [4:0]  excodeSel;
  logic [31:0] badvaddrSel;

  assign inRun      = (state_q == RUN);
  assign exStrobe   = wsValid_q & (intTag_q | (|exc_q)) & inRun;
  assign eretStrobe = wsValid_q & eret_q & ~exStrobe & inRun;
  assign flushNow   = exStrobe | eretStrobe;
  assign load       = bus.ms_to_ws_valid & inRun & ~flushNow;
  assign state_d    = flushNow ? FLUSH : RUN;
  assign wsValid_d  = load;

  // The winning cause decides both the code and which address CP0 sees as BadVAddr.
  always_comb begin
    excodeSel   = 5'h00;
    badvaddrSel = 32'h0;
    if (intTag_q) begin
      excodeSel = 5'h00;
    end else if (exc_q[0]) begin
      excodeSel   = 5'h04;
      badvaddrSel = pc_q;
    end else if (exc_q[1]) begin
      excodeSel = 5'h0a;
    end else if (exc_q[2]) begin
      excodeSel = 5'h0c;
    end else if (exc_q[3]) begin
      excodeSel = 5'h08;
    end else if (exc_q[4]) begin
      excodeSel = 5'h09;
    end else if (exc_q[5]) begin
      excodeSel   = 5'h04;
      badvaddrSel = dataAddr_q;
    end else if (exc_q[6]) begin
      excodeSel   = 5'h05;
      badvaddrSel = dataAddr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wsValid_q  <= 1'b0;
      pc_q       <= 32'h0;
      bd_q       <= 1'b0;
      exc_q      <= 7'h0;
      intTag_q   <= 1'b0;
      dataAddr_q <= 32'h0;
      eret_q     <= 1'b0;
      mtc0_q     <= 1'b0;
      cp0Addr_q  <= 8'h0;
      cp0Wdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      wsValid_q <= wsValid_d;
      if (load) begin
        pc_q       <= bus.ms_pc;
        bd_q       <= bus.ms_bd;
        exc_q      <= bus.ms_exc;
        intTag_q   <= bus.has_int;
        dataAddr_q <= bus.ms_data_addr;
        eret_q     <= bus.ms_eret;
        mtc0_q     <= bus.ms_mtc0;
        cp0Addr_q  <= bus.ms_cp0_addr;
        cp0Wdata_q <= bus.ms_cp0_wdata;
      end
    end
  end

  assign bus.ws_allowin = inRun;
  assign bus.ex         = exStrobe;
  assign bus.excode     = excodeSel;
  assign bus.bd         = bd_q;
  assign bus.m2s_pc     = pc_q;
  assign bus.badvaddr   = badvaddrSel;
  assign bus.eret_flush = eretStrobe;
  assign bus.mtc0_we    = wsValid_q & mtc0_q & ~exStrobe & inRun;
  assign bus.cp0_addr   = cp0Addr_q;
  assign bus.cp0_wdata  = cp0Wdata_q;
  assign bus.flush      = flushNow;
  assign bus.flush_pc   = exStrobe ? 32'hBFC00380 : (eretStrobe ? bus.epc : 32'h0);

endmodule

// File: tb/tb_exc_commit.sv
// Randomized and directed bench for exc_commit against a cause-table reference model.
module tb_exc_commit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  exc_commit_if bus();

  exc_commit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Currently driven inputs, mirrored so the model never reads the DUT.
  logic        dValid, dBd, dEret, dMtc0, dInt;
  logic [31:0] dPc, dAddr, dWdata, dEpc;
  logic [6:0]  dExc;
  logic [7:0]  dCp0a;

  // Reference: the instruction held in writeback and whether this cycle is the flush bubble.
  logic        mValid, mInFlush, mBd, mEret, mMtc0, mInt;
  logic [31:0] mPc, mAddr, mWdata;
  logic [6:0]  mExc;
  logic [7:0]  mCp0a;

  logic [4:0]  causeCode [8] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic b, input logic [6:0] e,
                               input logic [31:0] a, input logic er, input logic mt, input logic [7:0] ca,
                               input logic [31:0] wd, input logic hi, input logic [31:0] ep);
    dValid = v; dPc = pc; dBd = b; dExc = e; dAddr = a; dEret = er; dMtc0 = mt;
    dCp0a = ca; dWdata = wd; dInt = hi; dEpc = ep;
    bus.ms_to_ws_valid = v;  bus.ms_pc = pc;       bus.ms_bd = b;       bus.ms_exc = e;
    bus.ms_data_addr = a;    bus.ms_eret = er;     bus.ms_mtc0 = mt;    bus.ms_cp0_addr = ca;
    bus.ms_cp0_wdata = wd;   bus.has_int = hi;     bus.epc = ep;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, dEpc);
  endtask

  task automatic clearModel();
    mValid = 0; mInFlush = 0; mBd = 0; mEret = 0; mMtc0 = 0; mInt = 0;
    mPc = 0; mAddr = 0; mWdata = 0; mExc = 0; mCp0a = 0;
  endtask

  // Checks outputs against the model mid-cycle, then advances the model across one edge.
  task automatic step();
    logic [7:0]  causes;
    int          win;
    logic        eEx, eEret, eMtc0, eFlush, accept;
    logic [31:0] eFlushPc, eBad;
    #1;
    causes = {mExc, mInt};
    win = -1;
    for (int i = 7; i >= 0; i--) if (causes[i]) win = i;
    eEx    = mValid && !mInFlush && (win >= 0);
    eEret  = mValid && !mInFlush && mEret && !eEx;
    eMtc0  = mValid && !mInFlush && mMtc0 && !eEx;
    eFlush = eEx || eEret;
    eFlushPc = eEx ? 32'hBFC00380 : (eEret ? dEpc : 32'h0);
    eBad = (win == 1) ? mPc : ((win == 6 || win == 7) ? mAddr : 32'h0);
    checkOutput("ws_allowin", 32'(bus.ws_allowin), 32'(!mInFlush));
    checkOutput("ex",         32'(bus.ex),         32'(eEx));
    checkOutput("eret_flush", 32'(bus.eret_flush), 32'(eEret));
    checkOutput("mtc0_we",    32'(bus.mtc0_we),    32'(eMtc0));
    checkOutput("flush",      32'(bus.flush),      32'(eFlush));
    checkOutput("flush_pc",   bus.flush_pc,        eFlushPc);
    if (mValid) begin
      checkOutput("m2s_pc",    bus.m2s_pc,          mPc);
      checkOutput("bd",        32'(bus.bd),         32'(mBd));
      checkOutput("cp0_addr",  32'(bus.cp0_addr),   32'(mCp0a));
      checkOutput("cp0_wdata", bus.cp0_wdata,       mWdata);
    end
    if (eEx) begin
      checkOutput("excode",   32'(bus.excode), 32'(causeCode[win]));
      checkOutput("badvaddr", bus.badvaddr,    eBad);
    end
    accept = dValid && !mInFlush && !eFlush;
    @(posedge clk);
    mInFlush = eFlush;
    mValid   = accept;
    if (accept) begin
      mPc = dPc; mBd = dBd; mExc = dExc; mInt = dInt; mAddr = dAddr;
      mEret = dEret; mMtc0 = dMtc0; mCp0a = dCp0a; mWdata = dWdata;
    end
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ex"},        32'(bus.ex),         32'h0);
    checkOutput({tag, " flush"},     32'(bus.flush),      32'h0);
    checkOutput({tag, " eret"},      32'(bus.eret_flush), 32'h0);
    checkOutput({tag, " mtc0_we"},   32'(bus.mtc0_we),    32'h0);
    checkOutput({tag, " flush_pc"},  bus.flush_pc,        32'h0);
    checkOutput({tag, " m2s_pc"},    bus.m2s_pc,          32'h0);
    checkOutput({tag, " badvaddr"},  bus.badvaddr,        32'h0);
    checkOutput({tag, " cp0_wdata"}, bus.cp0_wdata,       32'h0);
    checkOutput({tag, " cp0_addr"},  32'(bus.cp0_addr),   32'h0);
  endtask

  initial begin
    logic [31:0] r;
    checks = 0;
    errors = 0;
    dEpc = 32'h0;
    reset = 1'b1;
    idle();
    clearModel();
    #3;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Overflow exception, then the flush bubble refuses input.
    applyStimulus(1'b1, 32'hBFC00100, 1'b0, 7'b0000100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    #1;
    checkOutput("ov ex",       32'(bus.ex),     32'h1);
    checkOutput("ov excode",   32'(bus.excode), 32'h0c);
    checkOutput("ov flush",    32'(bus.flush),  32'h1);
    checkOutput("ov flush_pc", bus.flush_pc,    32'hBFC00380);
    step();
    checkOutput("ov allowin", 32'(bus.ws_allowin), 32'h0);
    step();

    // Fetch ADEL outranks RI.
    applyStimulus(1'b1, 32'h00000003, 1'b0, 7'b0000011, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    checkOutput("adel excode",   32'(bus.excode), 32'h04);
    checkOutput("adel badvaddr", bus.badvaddr,    32'h00000003);
    step(); step();

    // ERET redirects to EPC and the instruction offered alongside is dropped.
    applyStimulus(1'b1, 32'h80001000, 1'b0, 7'h0, 32'h0, 1'b1, 1'b0, 8'h0, 32'h0, 1'b0, 32'hBFC00200);
    step();
    applyStimulus(1'b1, 32'h80001004, 1'b0, 7'b0000100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'hBFC00200);
    checkOutput("eret eret_flush", 32'(bus.eret_flush), 32'h1);
    checkOutput("eret ex",         32'(bus.ex),         32'h0);
    checkOutput("eret flush_pc",   bus.flush_pc,        32'hBFC00200);
    step();
    idle();
    step();
    checkOutput("eret dropped ex", 32'(bus.ex), 32'h0);
    step();

    // Interrupt on an MTC0 suppresses the CP0 write.
    applyStimulus(1'b1, 32'hBFC00010, 1'b0, 7'h0, 32'h0, 1'b0, 1'b1, 8'h60, 32'h0000FF01, 1'b1, 32'h0);
    step();
    idle();
    checkOutput("mtc0 ex",      32'(bus.ex),      32'h1);
    checkOutput("mtc0 excode",  32'(bus.excode),  32'h00);
    checkOutput("mtc0 we",      32'(bus.mtc0_we), 32'h0);
    step(); step();

    // Store ADES in a delay slot.
    applyStimulus(1'b1, 32'hBFC00304, 1'b1, 7'b1000000, 32'h80000002, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
    step();
    idle();
    checkOutput("ades ex",       32'(bus.ex),     32'h1);
    checkOutput("ades excode",   32'(bus.excode), 32'h05);
    checkOutput("ades badvaddr", bus.badvaddr,    32'h80000002);
    checkOutput("ades bd",       32'(bus.bd),     32'h1);
    checkOutput("ades m2s_pc",   bus.m2s_pc,      32'hBFC00304);
    step(); step();

    // Asynchronous reset while an excepting instruction is held.
    applyStimulus(1'b1, 32'hBFC00400, 1'b0, 7'b0000100, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("pre-reset ex", 32'(bus.ex), 32'h1);
    #2 reset = 1'b1;
    #1;
    checkAllZero("async reset");
    @(posedge clk);
    @(negedge clk);
    checkAllZero("held reset");
    reset = 1'b0;
    clearModel();
    idle();
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom;
      if (r[1:0] == 2'd0)      dExc = 7'(1 << $urandom_range(0, 6));
      else if (r[3:2] == 2'd0) dExc = 7'($urandom);
      else                     dExc = 7'h0;
      applyStimulus(($urandom % 10) < 7, $urandom, 1'($urandom), dExc, $urandom,
                    ($urandom % 7) == 0, ($urandom % 7) == 0, 8'($urandom), $urandom,
                    ($urandom % 10) == 0, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- ms_to_ws_valid  in  1  MEM stage offers an instruction.
- ws_allowin  out  1  this stage accepts an instruction this cycle.
- ms_pc  in  32  PC of the offered instruction.
- ms_bd  in  1  offered instruction sits in a delay slot.
- ms_exc  in  7  exception flags: [0] fetch ADEL, [1] RI, [2] OV, [3] SYSCALL, [4] BREAK, [5] load ADEL, [6] store ADES.
- ms_data_addr  in  32  data virtual address of the load/store.
- ms_eret  in  1  instruction is ERET.
- ms_mtc0  in  1  instruction is MTC0.
- ms_cp0_addr  in  8  CP0 register address, {rd,sel}.
- ms_cp0_wdata  in  32  MTC0 write data.
- has_int  in  1  interrupt pending from CP0.
- epc  in  32  EPC from CP0.
- ex  out  1  exception commit strobe to CP0.
- excode  out  5  exception code to CP0.
- bd  out  1  delay-slot flag to CP0.
- m2s_pc  out  32  PC of the committing instruction, to CP0.
- badvaddr  out  32  faulting address, to CP0.
- eret_flush  out  1  ERET commit strobe to CP0.
- mtc0_we  out  1  CP0 write strobe.
- cp0_addr  out  8  CP0 address.
- cp0_wdata  out  32  CP0 write data.
- flush  out  1  kill all younger stages.
- flush_pc  out  32  fetch redirect target.

REQ-002 SHALL use one clock domain, clk, with reset asynchronous and active-high.

Function
REQ-003 SHALL hold one WB register set: ws_valid, pc, bd, exc[6:0], int_tag, data_addr, eret, mtc0, cp0_addr, cp0_wdata.
REQ-004 SHALL implement two states:
- RUN: ws_allowin = 1.
- FLUSH: ws_allowin = 0; lasts exactly 1 cycle, then returns to RUN.
REQ-005 SHALL load the register when ms_to_ws_valid && ws_allowin && !flush; otherwise ws_valid SHALL go to 0 on the next edge (single-cycle stage, no hold).
REQ-006 SHALL set int_tag = has_int at the load edge; an interrupt is taken only on a valid instruction.
REQ-007 SHALL compute exception priority, highest first: int_tag (excode 0x00), fetch ADEL (0x04), RI (0x0a), OV (0x0c), SYSCALL (0x08), BREAK (0x09), load ADEL (0x04), store ADES (0x05).
REQ-008 SHALL drive ex = ws_valid && (int_tag || |exc) && state==RUN, combinationally from the register, high for one cycle per instruction.
REQ-009 SHALL drive badvaddr = pc for fetch ADEL, data_addr for load ADEL or store ADES, and 0 otherwise.
REQ-010 SHALL drive m2s_pc = pc and bd = bd unmodified; CP0 performs the delay-slot EPC adjustment.
REQ-011 SHALL drive eret_flush = ws_valid && eret && !ex && state==RUN.
REQ-012 SHALL drive mtc0_we = ws_valid && mtc0 && !ex && state==RUN; an excepting MTC0 SHALL NOT write.
REQ-013 SHALL drive cp0_addr and cp0_wdata from the register at all times, so CP0 read data is valid whenever ws_valid is high.
REQ-014 SHALL drive flush = ex | eret_flush.
REQ-015 SHALL drive flush_pc = 32'hBFC00380 on ex, epc on eret_flush, and 0 otherwise.
REQ-016 SHALL enter FLUSH on any cycle where flush = 1; the instruction offered in that cycle SHALL be discarded.
REQ-017 SHALL give ex precedence over eret_flush when an ERET also carries a fetch ADEL.
REQ-018 SHALL leave ex, eret_flush, mtc0_we and flush all 0 while in FLUSH, even if ws_valid is high.

Reset
REQ-019 SHALL, on reset assertion and without waiting for clk, set ws_valid = 0 and state = RUN.
REQ-020 SHALL, during reset, hold all strobe outputs at 0 and all data outputs at 0.
REQ-021 SHALL, after reset deasserts mid-operation, discard any instruction in flight; no strobe is emitted for it.

Verification
REQ-022 Load at pc=0xBFC00100, exc=7'b0000100 (OV) -> next cycle ex=1, excode=0x0c, flush=1, flush_pc=0xBFC00380; following cycle ws_allowin=0.
REQ-023 Load with exc=7'b0000011 (fetch ADEL + RI), pc=0x00000003 -> excode=0x04, badvaddr=0x00000003.
REQ-024 ERET with epc=0xBFC00200 -> eret_flush=1, ex=0, flush_pc=0xBFC00200; an instruction offered in the same cycle is dropped.
REQ-025 MTC0 addr=8'h60, wdata=0x0000FF01, has_int=1 at load -> ex=1, excode=0x00, mtc0_we=0.
REQ-026 Store ADES, data_addr=0x80000002, bd=1, pc=0xBFC00304 -> ex=1, excode=0x05, badvaddr=0x80000002, bd=1, m2s_pc=0xBFC00304.
REQ-027 Assert reset asynchronously while an excepting instruction is held -> ex and flush drop to 0 before the next clk edge; no strobe after release.
